sccb_controller_core: RTL and testbench
=======================================

# sccb_controller_core

Single-transaction SCCB (OV5640-style, I2C-like) bus master. It accepts a level-held read or write request carrying the device ID, register sub-address and write data. It serializes the request onto open-drain SDA and push-pull SCL. Read results return through a valid/ready response port. It sits between camera-init sequencing logic and the sensor's SCCB pins.

## Interface
- SCL_DIV, default 2500: clk cycles per SCL period; must be a multiple of 4 and at least 8; Q = SCL_DIV/4.
- SUB_ADDR_WIDTH, default 16: sub-address width; 8 or 16 only.

- clk  in  1  system clock; all logic on rising edge.
- rest  in  1  reset; one clock; reset is synchronous and active-high.
- device_addr  in  8  8-bit write ID (e.g. 8'h78); bit0 ignored, replaced by R/W bit.
- sub_addr  in  SUB_ADDR_WIDTH  register address, sent MSB byte first.
- read  in  1  level request: read one byte.
- write  in  1  level request: write one byte; wins over read if both are high.
- write_data  in  8  byte for write.
- request_done  out  1  one-cycle pulse when a transaction's final STOP completes.
- read_data  out  8  last byte read; holds until the next read completes.
- resp_valid  out  1  read_data valid; held until accepted.
- resp_ready  in  1  response accept.
- sccb_scl  out  1  SCCB clock; idle high.
- sccb_sda  inout  1  open-drain: driven 0 or released (Z); never driven 1.

## Operation
- States: IDLE, START, BYTE (8 data bits plus 9th don't-care bit), STOP, RESTART_GAP, DONE.
- IDLE: request sampled every cycle; write>read. A read is not started while resp_valid=1 and resp_ready=0.
- Request inputs (device_addr, sub_addr, write_data) are latched at acceptance; later changes are ignored.
- Write: START, {device_addr[7:1],0}, sub_addr bytes, write_data, STOP.
- Read, 2-phase: START, {id,0}, sub_addr bytes, STOP; then START, {id,1}, 8 bits read MSB first, 9th bit master releases SDA (NA=1), STOP.
- 9th bit after master-sent bytes: SDA released, value ignored.
- DONE: request_done=1 for one cycle. For a read, read_data is updated and resp_valid is set in that same cycle. Return to IDLE.
- Level requests still high in IDLE start a new transaction; the requester deasserts on request_done.
- resp_valid clears on the cycle after resp_valid&&resp_ready.
- Reset at any time: abort with no request_done. SCL=1, SDA released, resp_valid=0, read_data=0, request_done=0.

## Timing
- Every bit = one SCL period = 4Q cycles.
  - Q0–Q1: SCL low; SDA updated at Q0 start.
  - Q2–Q3: SCL high; read data sampled at the first cycle of Q3.
- START = one period:
  - SDA released, SCL high for 2Q.
  - SDA low, SCL high for 2Q.
- STOP = one period:
  - SCL low, SDA low for 2Q.
  - SCL high, SDA low for Q.
  - SDA released for Q.
- Byte = 9 periods. N_SUB = SUB_ADDR_WIDTH/8.
- Write: acceptance to request_done = (2 + 9*(2+N_SUB))*SCL_DIV cycles; 38*SCL_DIV for 16-bit.
- Read: (2+9*(1+N_SUB)) + (2+18) periods; 49*SCL_DIV for 16-bit.
- Accept: request sampled in IDLE; START begins next cycle.

## Configuration
- SCCB_RESTART_READ_EN defined: the read replaces phase-1 STOP plus START with a single repeated-START period: SCL low, SDA released Q; SCL high Q; SDA low 2Q. 16-bit read = 48*SCL_DIV cycles.
- Undefined: 2-phase STOP/START read as above.

## Test plan
- Reset: rest=1 for 3 cycles -> sccb_scl=1, sda=Z, resp_valid=0, read_data=0, request_done=0.
- Write, SCL_DIV=8, id 8'h78, sub 16'h3008, data 8'h82 -> bus bytes 78,30,08,82 with a STOP; request_done pulse exactly 304 cycles after acceptance; resp_valid stays 0.
- Read, sub 16'h300E, slave model returns 8'h56 -> bytes 78,30,0E, STOP/START, 79, then read 56 with NA=1. Result: read_data=8'h56, resp_valid=1 at 392 cycles, with request_done pulsing on the same cycle.
- Backpressure: resp_ready=0 with read held high -> no new START while resp_valid=1. Raise resp_ready -> resp_valid clears next cycle, then a new read starts.
- read and write both high -> write sequence is issued.
- Reset asserted mid-byte -> SCL=1 and SDA=Z next cycle; no request_done; a later write completes normally.

Source files
------------

// File: rtl/sccb_controller_core.sv
// SCCB (OV5640-style) single-transaction bus master.
// Accepts a level-held read/write request, serializes it onto push-pull SCL and
// open-drain SDA, and returns read bytes through a valid/ready response port.
// Optional feature macro: SCCB_RESTART_READ_EN -- when defined, a read joins its
// address phase and data phase with one repeated-START period instead of STOP+START.
module sccb_controller_core #(
  parameter int unsigned SCL_DIV        = 2500,
  parameter int unsigned SUB_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rest,
  input  logic [7:0]                device_addr,
  input  logic [SUB_ADDR_WIDTH-1:0] sub_addr,
  input  logic                      read,
  input  logic                      write,
  input  logic [7:0]                write_data,
  output logic                      request_done,
  output logic [7:0]                read_data,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      sccb_scl,
  inout  wire                       sccb_sda
);

  localparam int unsigned NSub = SUB_ADDR_WIDTH / 8;
  localparam int unsigned Q    = SCL_DIV / 4;
  localparam int unsigned CntW = $clog2(SCL_DIV);
  localparam int unsigned TxW  = 8 * (NSub + 2);

  localparam logic [CntW-1:0] CntQ1      = CntW'(Q);
  localparam logic [CntW-1:0] CntQ2      = CntW'(2 * Q);
  localparam logic [CntW-1:0] CntQ3      = CntW'(3 * Q);
  localparam logic [CntW-1:0] CntLast    = CntW'(SCL_DIV - 1);
  localparam logic [CntW-1:0] CntPreLast = CntW'(SCL_DIV - 2);
  localparam logic [1:0]      IdxWrLast  = 2'(NSub + 1);
  localparam logic [1:0]      IdxRdLast  = 2'(NSub);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StByte,
    StStop,
    StRestartGap,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic [1:0]          idx_q, idx_d;
  logic                is_read_q, is_read_d;
  logic                phase2_q, phase2_d;
  logic [6:0]          id_q, id_d;
  logic [TxW-1:0]      tx_q, tx_d;
  logic [7:0]          rx_q, rx_d;
  logic [7:0]          read_data_q, read_data_d;
  logic                resp_valid_q, resp_valid_d;

  logic                period_end;
  logic [1:0]          last_idx;
  logic                sda_low;
  logic                unused_id_lsb;

  // The R/W bit replaces the LSB of the device ID.
  assign unused_id_lsb = device_addr[0];

  assign period_end = (cnt_q == CntLast);
  // Address phase of a read ends after the sub-address; data phase is ID + one read byte.
  assign last_idx   = phase2_q ? 2'd1 : (is_read_q ? IdxRdLast : IdxWrLast);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      idx_q        <= '0;
      is_read_q    <= 1'b0;
      phase2_q     <= 1'b0;
      id_q         <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      read_data_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      idx_q        <= idx_d;
      is_read_q    <= is_read_d;
      phase2_q     <= phase2_d;
      id_q         <= id_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      read_data_q  <= read_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Next-state: request acceptance, bit/byte sequencing, read capture, response handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = period_end ? '0 : cnt_q + CntW'(1);
    bit_d        = bit_q;
    idx_d        = idx_q;
    is_read_d    = is_read_q;
    phase2_d     = phase2_q;
    id_d         = id_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    read_data_d  = read_data_q;
    resp_valid_d = resp_valid_q;

    if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (write || (read && !(resp_valid_q && !resp_ready))) begin
          state_d   = StStart;
          is_read_d = !write;
          phase2_d  = 1'b0;
          bit_d     = '0;
          idx_d     = '0;
          id_d      = device_addr[7:1];
          // A read's trailing byte slot is all ones so SDA stays released there.
          tx_d      = {device_addr[7:1], 1'b0, sub_addr, (write ? write_data : 8'hFF)};
        end
      end
      StStart: begin
        if (period_end) begin
          state_d = StByte;
          bit_d   = '0;
          idx_d   = '0;
        end
      end
      StByte: begin
        if (phase2_q && (idx_q == 2'd1) && (bit_q < 4'd8) && (cnt_q == CntQ3)) begin
          rx_d = {rx_q[6:0], sccb_sda};
        end
        if (period_end) begin
          if (bit_q == 4'd8) begin
            bit_d = '0;
            if (idx_q == last_idx) begin
`ifdef SCCB_RESTART_READ_EN
              if (is_read_q && !phase2_q) begin
                state_d  = StRestartGap;
                phase2_d = 1'b1;
                tx_d     = {id_q, 1'b1, {(TxW - 8){1'b1}}};
              end else begin
                state_d = StStop;
              end
`else
              state_d = StStop;
`endif
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = {tx_q[TxW-2:0], 1'b1};
          end
        end
      end
      StStop: begin
        if (!is_read_q || phase2_q) begin
          // The last cycle of the final STOP period is the DONE cycle.
          if (cnt_q == CntPreLast) begin
            state_d = StDone;
            if (is_read_q) begin
              read_data_d  = rx_q;
              resp_valid_d = 1'b1;
            end
          end
        end else if (period_end) begin
          state_d  = StStart;
          phase2_d = 1'b1;
          tx_d     = {id_q, 1'b1, {(TxW - 8){1'b1}}};
        end
      end
      StRestartGap: begin
        if (period_end) begin
          state_d = StByte;
          bit_d   = '0;
          idx_d   = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus waveform decode from state and position within the SCL period.
  always_comb begin
    sccb_scl = 1'b1;
    sda_low  = 1'b0;
    case (state_q)
      StStart: begin
        sda_low = (cnt_q >= CntQ2);
      end
      StByte: begin
        sccb_scl = (cnt_q >= CntQ2);
        sda_low  = (bit_q < 4'd8) && !tx_q[TxW-1];
      end
      StStop: begin
        sccb_scl = (cnt_q >= CntQ2);
        sda_low  = (cnt_q < CntQ3);
      end
      StRestartGap: begin
        sccb_scl = (cnt_q >= CntQ1);
        sda_low  = (cnt_q >= CntQ2);
      end
      default: begin
        sccb_scl = 1'b1;
        sda_low  = 1'b0;
      end
    endcase
  end

  assign sccb_sda     = sda_low ? 1'b0 : 1'bz;
  assign request_done = (state_q == StDone);
  assign read_data    = read_data_q;
  assign resp_valid   = resp_valid_q;

endmodule

// File: tb/tb_sccb_controller_core.sv
// Directed bench for sccb_controller_core with a bus monitor and read-slave model.
module tb_sccb_controller_core;

  localparam int Div     = 8;
  localparam int WrLat   = 38 * Div;
`ifdef SCCB_RESTART_READ_EN
  localparam int ReadLat = 48 * Div;
`else
  localparam int ReadLat = 49 * Div;
`endif
  localparam int StartMk = 'h1000;
  localparam int StopMk  = 'h2000;

  logic        clk = 1'b0;
  logic        rest;
  logic [7:0]  device_addr;
  logic [15:0] sub_addr;
  logic        read;
  logic        write;
  logic [7:0]  write_data;
  logic        request_done;
  logic [7:0]  read_data;
  logic        resp_valid;
  logic        resp_ready;
  logic        sccb_scl;
  wire         sda_w;
  logic        slave_low = 1'b0;

  pullup (sda_w);
  assign sda_w = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  sccb_controller_core #(
    .SCL_DIV       (Div),
    .SUB_ADDR_WIDTH(16)
  ) dut (
    .clk         (clk),
    .rest        (rest),
    .device_addr (device_addr),
    .sub_addr    (sub_addr),
    .read        (read),
    .write       (write),
    .write_data  (write_data),
    .request_done(request_done),
    .read_data   (read_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .sccb_scl    (sccb_scl),
    .sccb_sda    (sda_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bus monitor: logs START/STOP markers and each 9-bit byte as {byte, 9th bit}.
  // It also acts as the slave for reads, shifting out slave_byte after a read ID.
  logic       scl_p = 1'b1;
  logic       sda_p = 1'b1;
  int         bcnt = 0;
  int         frame_bytes = 0;
  int         rd_bit = 0;
  logic       reading = 1'b0;
  logic [7:0] shreg = '0;
  logic [7:0] slave_byte = '0;
  int         log_q[$];
  int         exp_q[$];

  always @(posedge clk) begin
    scl_p <= sccb_scl;
    sda_p <= sda_w;
    if (rest) begin
      bcnt      <= 0;
      reading   <= 1'b0;
      slave_low <= 1'b0;
    end else if (scl_p && sccb_scl && sda_p && !sda_w) begin
      log_q.push_back(StartMk);
      bcnt        <= 0;
      frame_bytes <= 0;
    end else if (scl_p && sccb_scl && !sda_p && sda_w) begin
      log_q.push_back(StopMk);
      bcnt <= 0;
    end else if (!scl_p && sccb_scl) begin
      if (bcnt == 8) begin
        log_q.push_back(int'({shreg, sda_w}));
        bcnt        <= 0;
        frame_bytes <= frame_bytes + 1;
        if (frame_bytes == 0 && shreg[0]) begin
          reading <= 1'b1;
          rd_bit  <= 0;
        end
      end else begin
        shreg <= {shreg[6:0], sda_w};
        bcnt  <= bcnt + 1;
      end
    end else if (scl_p && !sccb_scl && reading) begin
      if (rd_bit < 8) begin
        slave_low <= ~slave_byte[7-rd_bit];
        rd_bit    <= rd_bit + 1;
      end else begin
        slave_low <= 1'b0;
        reading   <= 1'b0;
      end
    end
  end

  // Expected bus log; the master never acks, so every 9th bit reads back as 1.
  task automatic build_exp(input logic wr, input logic [7:0] id, input logic [15:0] sub,
                           input logic [7:0] wd, input logic [7:0] sb);
    exp_q.delete();
    exp_q.push_back(StartMk);
    exp_q.push_back(int'({id[7:1], 1'b0, 1'b1}));
    exp_q.push_back(int'({sub[15:8], 1'b1}));
    exp_q.push_back(int'({sub[7:0], 1'b1}));
    if (wr) begin
      exp_q.push_back(int'({wd, 1'b1}));
    end else begin
`ifndef SCCB_RESTART_READ_EN
      exp_q.push_back(StopMk);
`endif
      exp_q.push_back(StartMk);
      exp_q.push_back(int'({id[7:1], 1'b1, 1'b1}));
      exp_q.push_back(int'({sb, 1'b1}));
    end
    exp_q.push_back(StopMk);
  endtask

  task automatic check_log(input string name);
    int n;
    int first;
    n = 0;
    first = -1;
    check({name, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      if (log_q[i] != exp_q[i]) begin
        n++;
        if (first < 0) first = i;
      end
    end
    if (n != 0) $display("  first differing entry %0d: got %0h want %0h", first,
                         log_q[first], exp_q[first]);
    check({name, "_entries_differing"}, n, 0);
  endtask

  // Issue a request in the IDLE cycle and wait (bounded) for request_done.
  task automatic run_txn(input logic wr, input logic rd, input logic [7:0] id,
                         input logic [15:0] sub, input logic [7:0] wd,
                         output int lat, output logic rv_during,
                         output logic rv_done, output logic [7:0] rd_done);
    @(negedge clk);
    log_q.delete();
    write = wr;
    read = rd;
    device_addr = id;
    sub_addr = sub;
    write_data = wd;
    lat = -1;
    rv_during = 1'b0;
    rv_done = 1'b0;
    rd_done = '0;
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        // Latched at acceptance; these changes must not reach the bus.
        device_addr = ~id;
        sub_addr = ~sub;
        write_data = ~wd;
      end
      if (request_done) begin
        lat = n;
        rv_done = resp_valid;
        rd_done = read_data;
        write = 1'b0;
        read = 1'b0;
        break;
      end
      if (resp_valid) rv_during = 1'b1;
    end
    write = 1'b0;
    read = 1'b0;
  endtask

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [7:0]  id;
    logic [15:0] sub;
    logic [7:0]  wd;
    logic [7:0]  sb;
    logic [15:0] lat;
    logic        rv;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int         lat;
    logic       rv_during;
    logic       rv_done;
    logic [7:0] rd_done;
    int         cnt;
    int         drops;
    logic       started;

    vecs[0] = '{1'b1, 1'b0, 8'h78, 16'h3008, 8'h82, 8'h00, 16'(WrLat), 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'h78, 16'h300E, 8'h00, 8'h56, 16'(ReadLat), 1'b1, 8'h56};
    vecs[2] = '{1'b1, 1'b1, 8'h78, 16'h1234, 8'hA5, 8'h00, 16'(WrLat), 1'b0, 8'h56};
    vecs[3] = '{1'b0, 1'b1, 8'h43, 16'h00FF, 8'h00, 8'hA3, 16'(ReadLat), 1'b1, 8'hA3};

    rest = 1'b1;
    device_addr = '0;
    sub_addr = '0;
    read = 1'b0;
    write = 1'b0;
    write_data = '0;
    resp_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_scl", int'(sccb_scl), 1);
    check("reset_sda", int'(sda_w), 1);
    check("reset_resp_valid", int'(resp_valid), 0);
    check("reset_read_data", int'(read_data), 0);
    check("reset_request_done", int'(request_done), 0);
    rest = 1'b0;

    // Table-driven transactions.
    for (int v = 0; v < 4; v++) begin
      slave_byte = vecs[v].sb;
      run_txn(vecs[v].wr, vecs[v].rd, vecs[v].id, vecs[v].sub, vecs[v].wd,
              lat, rv_during, rv_done, rd_done);
      build_exp(vecs[v].wr, vecs[v].id, vecs[v].sub, vecs[v].wd, vecs[v].sb);
      check($sformatf("v%0d_latency", v), lat, int'(vecs[v].lat));
      check($sformatf("v%0d_resp_valid_at_done", v), int'(rv_done), int'(vecs[v].rv));
      check($sformatf("v%0d_read_data_at_done", v), int'(rd_done), int'(vecs[v].rdata));
      check($sformatf("v%0d_resp_valid_early", v), int'(rv_during), 0);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", v), int'(request_done), 0);
      check($sformatf("v%0d_resp_valid_cleared", v), int'(resp_valid), 0);
      check_log($sformatf("v%0d_bus", v));
    end

    // Backpressure: pending unaccepted response blocks a held read.
    resp_ready = 1'b0;
    slave_byte = 8'h3C;
    run_txn(1'b0, 1'b1, 8'h78, 16'h0102, 8'h00, lat, rv_during, rv_done, rd_done);
    check("bp_latency", lat, ReadLat);
    check("bp_read_data", int'(rd_done), 'h3C);
    read = 1'b1;
    cnt = 0;
    drops = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!sccb_scl || !sda_w) cnt++;
      if (!resp_valid) drops++;
    end
    check("bp_no_bus_activity", cnt, 0);
    check("bp_resp_valid_held", drops, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_resp_valid_clears", int'(resp_valid), 0);
    started = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sccb_scl && !sda_w) begin
        started = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bp_new_start", int'(started), 1);
    read = 1'b0;
    lat = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (request_done) begin
        lat = n;
        break;
      end
    end
    check("bp_second_read_done", int'(lat >= 0), 1);
    check("bp_second_read_data", int'(read_data), 'h3C);

    // Reset mid-byte: bit 7 of the ID byte (0) is on the bus with SCL low at cycle 66.
    @(negedge clk);
    log_q.delete();
    write = 1'b1;
    device_addr = 8'h78;
    sub_addr = 16'h5566;
    write_data = 8'h77;
    repeat (66) @(negedge clk);
    check("pre_reset_scl", int'(sccb_scl), 0);
    check("pre_reset_sda", int'(sda_w), 0);
    rest = 1'b1;
    write = 1'b0;
    @(negedge clk);
    check("mid_reset_scl", int'(sccb_scl), 1);
    check("mid_reset_sda", int'(sda_w), 1);
    check("mid_reset_request_done", int'(request_done), 0);
    check("mid_reset_resp_valid", int'(resp_valid), 0);
    check("mid_reset_read_data", int'(read_data), 0);
    rest = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (request_done || !sccb_scl || !sda_w) cnt++;
    end
    check("post_reset_quiet", cnt, 0);
    run_txn(1'b1, 1'b0, 8'h78, 16'h5566, 8'h77, lat, rv_during, rv_done, rd_done);
    build_exp(1'b1, 8'h78, 16'h5566, 8'h77, 8'h00);
    check("post_reset_write_latency", lat, WrLat);
    check_log("post_reset_bus");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
